cpu_run_ctrl: RTL and testbench
===============================

# cpu_run_ctrl

Run/step/breakpoint sequencer for the single-cycle RISC-V core. It produces a one-cycle clock-enable, `cpu_en_o`, that gates the PC, register-file and data-memory updates. This replaces the switch-selected divided CPU clock with a single-clock, enable-based scheme. It sits between the board switches/buttons and the core, and exports run state and a retired-instruction count for the seven-segment display mux.

## Interface
Parameters:
- `PC_W`, 6: width of the instruction-ROM word address (PC) compared for breakpoints.
- `CNT_W`, 26: prescaler counter width.

Ports (clock and reset first):
- `clk`  in  1  system clock. One clock domain; reset is asynchronous and active-high.
- `rst`  in  1  asynchronous, active-high reset.
- `run_i`  in  1  level from a board switch; 1 requests free-running execution. Asynchronous to `clk`.
- `step_i`  in  1  level from a debounced button; each rising edge requests one instruction. Asynchronous to `clk`.
- `div_sel_i`  in  2  run-rate select: 00 issues every cycle, 01 every 2^16, 10 every 2^22, 11 every 2^25 cycles.
- `bp_en_i`  in  1  breakpoint enable.
- `bp_addr_i`  in  PC_W  breakpoint word address.
- `pc_i`  in  PC_W  current core PC (word address).
- `cpu_en_o`  out  1  registered one-cycle enable; the core commits one instruction per high cycle.
- `state_o`  out  2  current FSM state: 0 HALT, 1 RUN, 2 STEP, 3 BREAK.
- `bp_hit_o`  out  1  high while in BREAK.
- `retired_o`  out  32  count of `cpu_en_o` pulses.

## Operation
- `run_i` and `step_i` each pass through a 2-flop synchronizer. `step_i` additionally has a rise detector, giving `step_pulse` = sync & ~prev.
- HALT:
  - `step_pulse` → STEP.
  - else synced run=1 → RUN, with the prescaler cleared and `skip_bp` set.
- RUN:
  - `tick` = low k prescaler bits all ones, where k = 0/16/22/25 per `div_sel_i`; k=0 means tick every cycle.
  - On `tick` with `bp_en_i` & (`pc_i`==`bp_addr_i`) & ~`skip_bp` → BREAK; no enable is issued.
  - Otherwise, on `tick`, `cpu_en_o` is set next cycle and `skip_bp` is cleared.
  - Synced run=0 → HALT, taking priority over `tick`; no enable is issued that cycle.
- STEP: `cpu_en_o` is set for exactly one cycle, then the FSM returns to HALT. The breakpoint is ignored.
- BREAK:
  - `step_pulse` → STEP, which steps past the breakpoint.
  - Synced run=0 → HALT.
  - Step takes priority if both occur in the same cycle.
  - Re-entering RUN at the breakpoint PC does not re-break on the first tick (`skip_bp`).
- HALT with `step_pulse` and run=1 in the same cycle: step wins.
- `step_pulse` while in RUN or STEP is discarded and not queued.
- `retired_o` increments in every cycle where `cpu_en_o`=1 and wraps modulo 2^32. It is cleared only by `rst`.
- `div_sel_i` changes take effect on the next cycle; the prescaler is not cleared.

## Timing
- Reset values: state HALT; `cpu_en_o`=0, `bp_hit_o`=0, `state_o`=0, `retired_o`=0; prescaler, synchronizers and `skip_bp` all 0. Reset acts immediately on assertion, including mid-pulse.
- Step latency: with clock edge e0 the first to sample `step_i`=1, the FSM enters STEP at e2 and `cpu_en_o` is high from e3 to e4.
- Run latency: HALT→RUN happens 2 edges after `run_i` is sampled. With `div_sel_i`=00, `cpu_en_o` is then high every cycle starting one cycle after RUN is entered.
- Pulse spacing: `cpu_en_o` is never high for two consecutive cycles, except in RUN with `div_sel_i`=00.
- Breakpoint: the comparison uses `pc_i` in the tick cycle. `pc_i` changes only after an enable.

## Structure
- Package `cpu_dbg_pkg`: state encoding (HALT, RUN, STEP, BREAK) and div-tap constants (0, 16, 22, 25).
- Sub-module `sync_edge`: 2-flop synchronizer plus registered previous value; outputs level and rise. Instantiated for `run_i` and `step_i`.

## Test plan
- Reset, then one `step_i` pulse with `div_sel_i`=00 → exactly one `cpu_en_o` cycle, 3 edges after sampling; `retired_o`=1; `state_o` returns to 0.
- `run_i`=1 with `div_sel_i`=00 for 20 cycles, then 0 → `cpu_en_o` high on consecutive cycles. `retired_o` equals the counted pulses, and no pulse follows the HALT decision.
- `bp_en_i`=1, `bp_addr_i`=5, model PC incrementing on each enable from 0, then run → 5 pulses, BREAK with `bp_hit_o`=1, `pc_i`=5. A step then gives 1 pulse; `run_i` toggled 0→1 resumes without re-breaking at PC 5.
- `rst` asserted during RUN while `cpu_en_o`=1 → all outputs 0 immediately. After release the FSM stays in HALT until a new request.
- `step_i` and `run_i` rising together in HALT → STEP first (1 pulse), then RUN. A `step_i` edge during RUN produces no extra pulse.
- `retired_o` forced to 32'hFFFFFFFF via hierarchical deposit, then one step → `retired_o` wraps to 0.

Source files
------------

// File: rtl/cpu_dbg_pkg.sv
// Shared encodings for the CPU run/step/breakpoint sequencer:
// FSM state codes and the prescaler tap positions selected by div_sel.
package cpu_dbg_pkg;

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_BREAK = 2'd3
  } run_state_e;

  localparam int unsigned RET_W     = 32;
  localparam int unsigned DIV_SEL_W = 2;

  localparam int unsigned DIV_TAP_0 = 0;
  localparam int unsigned DIV_TAP_1 = 16;
  localparam int unsigned DIV_TAP_2 = 22;
  localparam int unsigned DIV_TAP_3 = 25;

  // Number of low prescaler bits that must all be ones for a run tick.
  function automatic int unsigned div_tap(input logic [DIV_SEL_W-1:0] sel);
    int unsigned tap;
    case (sel)
      2'b00:   tap = DIV_TAP_0;
      2'b01:   tap = DIV_TAP_1;
      2'b10:   tap = DIV_TAP_2;
      default: tap = DIV_TAP_3;
    endcase
    return tap;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous level, plus a registered copy of
// the synchronized value so a one-cycle rising-edge strobe can be formed.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise_c
);

  logic s1_q;
  logic s2_q;
  logic prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= d;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign level  = s2_q;
  assign rise_c = s2_q & ~prev_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step/breakpoint sequencer: issues one-cycle commit enables to the
// single-cycle core and counts retired instructions for the display.
module cpu_run_ctrl
  import cpu_dbg_pkg::*;
#(
  parameter int unsigned PC_W  = 6,
  parameter int unsigned CNT_W = 26
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run_i,
  input  logic                 step_i,
  input  logic [DIV_SEL_W-1:0] div_sel_i,
  input  logic                 bp_en_i,
  input  logic [PC_W-1:0]      bp_addr_i,
  input  logic [PC_W-1:0]      pc_i,
  output logic                 cpu_en_o,
  output logic [1:0]           state_o,
  output logic                 bp_hit_o,
  output logic [RET_W-1:0]     retired_o
);

  logic run_s;
  logic run_rise_unused;
  logic step_s_unused;
  logic step_pulse;

  run_state_e         state_q;
  run_state_e         state_d;
  logic               cpu_en_q;
  logic               cpu_en_d;
  logic               bp_hit_q;
  logic               skip_bp_q;
  logic               skip_bp_d;
  logic               presc_clr;
  logic [CNT_W-1:0]   presc_q;
  logic [CNT_W-1:0]   tap_mask;
  logic               tick;
  logic               bp_match;
  logic [RET_W-1:0]   retired_q;

  sync_edge u_run_sync (
    .clk    (clk),
    .rst    (rst),
    .d      (run_i),
    .level  (run_s),
    .rise_c (run_rise_unused)
  );

  sync_edge u_step_sync (
    .clk    (clk),
    .rst    (rst),
    .d      (step_i),
    .level  (step_s_unused),
    .rise_c (step_pulse)
  );

  // Low-k bit mask for the selected rate; an empty mask ticks every cycle.
  always_comb begin
    tap_mask = '0;
    for (int unsigned i = 0; i < CNT_W; i++) begin
      tap_mask[i] = (i < div_tap(div_sel_i));
    end
  end

  assign tick     = &(presc_q | ~tap_mask);
  assign bp_match = bp_en_i & (pc_i == bp_addr_i);

  // Next-state and enable decision.
  always_comb begin
    state_d   = state_q;
    cpu_en_d  = 1'b0;
    skip_bp_d = skip_bp_q;
    presc_clr = 1'b0;
    case (state_q)
      ST_HALT: begin
        if (step_pulse) begin
          state_d = ST_STEP;
        end else if (run_s) begin
          state_d   = ST_RUN;
          presc_clr = 1'b1;
          skip_bp_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (!run_s) begin
          state_d = ST_HALT;
        end else if (tick) begin
          if (bp_match && !skip_bp_q) begin
            state_d = ST_BREAK;
          end else begin
            cpu_en_d  = 1'b1;
            skip_bp_d = 1'b0;
          end
        end
      end
      ST_STEP: begin
        cpu_en_d = 1'b1;
        state_d  = ST_HALT;
      end
      ST_BREAK: begin
        if (step_pulse) begin
          state_d = ST_STEP;
        end else if (!run_s) begin
          state_d = ST_HALT;
        end
      end
      default: state_d = ST_HALT;
    endcase
  end

  // FSM and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_HALT;
      cpu_en_q  <= 1'b0;
      bp_hit_q  <= 1'b0;
      skip_bp_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cpu_en_q  <= cpu_en_d;
      bp_hit_q  <= (state_d == ST_BREAK);
      skip_bp_q <= skip_bp_d;
    end
  end

  // Free-running prescaler, restarted on every entry into RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
    end else if (presc_clr) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_q <= '0;
    end else if (cpu_en_q) begin
      retired_q <= retired_q + RET_W'(1);
    end
  end

  assign cpu_en_o  = cpu_en_q;
  assign state_o   = state_q;
  assign bp_hit_o  = bp_hit_q;
  assign retired_o = retired_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: a PC model advances on each observed
// enable and every enable is matched against a queue of expected PCs.
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run_i = 1'b0;
  logic        step_i = 1'b0;
  logic [1:0]  div_sel_i = 2'b00;
  logic        bp_en_i = 1'b0;
  logic [5:0]  bp_addr_i = '0;
  logic [5:0]  pc_model = '0;
  logic        cpu_en_o;
  logic [1:0]  state_o;
  logic        bp_hit_o;
  logic [31:0] retired_o;

  int          vectors = 0;
  int          errors = 0;
  logic [5:0]  exp_q[$];
  logic [31:0] exp_retired = '0;

  cpu_run_ctrl #(.PC_W(6), .CNT_W(26)) dut (
    .clk       (clk),
    .rst       (rst),
    .run_i     (run_i),
    .step_i    (step_i),
    .div_sel_i (div_sel_i),
    .bp_en_i   (bp_en_i),
    .bp_addr_i (bp_addr_i),
    .pc_i      (pc_model),
    .cpu_en_o  (cpu_en_o),
    .state_o   (state_o),
    .bp_hit_o  (bp_hit_o),
    .retired_o (retired_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Queue the PCs at which the next enables are expected.
  task automatic push_pcs(input int first, input int count);
    for (int i = 0; i < count; i++) exp_q.push_back(6'(first + i));
    exp_retired = exp_retired + 32'(count);
  endtask

  task automatic wait_state(input string tag, input logic [1:0] s, input int bound);
    for (int n = 0; n < bound; n++) begin
      if (state_o === s) break;
      tick();
    end
    check(tag, 32'(state_o), 32'(s));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ticks(2);
    @(negedge clk);
    rst = 1'b0;
    exp_retired = '0;
  endtask

  // Core model: PC advances once per enable; each enable must be expected.
  always @(negedge clk) begin
    if (rst) begin
      pc_model = '0;
    end else if (cpu_en_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $error("FAIL unexpected_pulse observed pc=%0d expected=no enable", pc_model);
      end else begin
        check("pulse_pc", 32'(pc_model), 32'(exp_q.pop_front()));
      end
      pc_model = pc_model + 6'd1;
    end
  end

  initial begin
    ticks(3);
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_cpu_en", 32'(cpu_en_o), 32'd0);
    check("rst_bp_hit", 32'(bp_hit_o), 32'd0);
    check("rst_retired", retired_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single step: STEP at e2, enable from e3 to e4.
    push_pcs(0, 1);
    @(negedge clk);
    step_i = 1'b1;
    ticks(3);
    check("step_state_e2", 32'(state_o), 32'd2);
    check("step_en_e2", 32'(cpu_en_o), 32'd0);
    tick();
    check("step_en_e3", 32'(cpu_en_o), 32'd1);
    check("step_state_e3", 32'(state_o), 32'd0);
    tick();
    check("step_en_e4", 32'(cpu_en_o), 32'd0);
    check("step_retired", retired_o, exp_retired);
    @(negedge clk);
    step_i = 1'b0;
    ticks(4);

    // Free run at full rate for 20 sampled cycles: 19 back-to-back enables.
    push_pcs(1, 19);
    @(negedge clk);
    run_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 2) check("run_enter", 32'(state_o), 32'd1);
      if (i == 2) check("run_first_gap", 32'(cpu_en_o), 32'd0);
      if (i == 3) check("run_first_en", 32'(cpu_en_o), 32'd1);
    end
    @(negedge clk);
    run_i = 1'b0;
    ticks(2);
    check("run_last_en", 32'(cpu_en_o), 32'd1);
    tick();
    check("run_halt_state", 32'(state_o), 32'd0);
    check("run_halt_no_en", 32'(cpu_en_o), 32'd0);
    ticks(4);
    check("run_queue_drained", 32'(exp_q.size()), 32'd0);
    check("run_retired", retired_o, exp_retired);

    // Breakpoint at 5, step past it, run to 8, then resume at 8 without re-breaking.
    do_reset();
    bp_en_i = 1'b1;
    bp_addr_i = 6'd5;
    push_pcs(0, 5);
    @(negedge clk);
    run_i = 1'b1;
    wait_state("bp_reach_break", 2'd3, 40);
    check("bp_hit", 32'(bp_hit_o), 32'd1);
    check("bp_pc", 32'(pc_model), 32'd5);
    check("bp_retired", retired_o, exp_retired);
    check("bp_queue_drained", 32'(exp_q.size()), 32'd0);
    push_pcs(5, 3);
    @(negedge clk);
    bp_addr_i = 6'd8;
    step_i = 1'b1;
    ticks(3);
    check("bp_step_state", 32'(state_o), 32'd2);
    check("bp_step_hit_clr", 32'(bp_hit_o), 32'd0);
    @(negedge clk);
    step_i = 1'b0;
    wait_state("bp_reach_break8", 2'd3, 40);
    check("bp8_pc", 32'(pc_model), 32'd8);
    @(negedge clk);
    run_i = 1'b0;
    wait_state("bp_to_halt", 2'd0, 10);
    push_pcs(8, 64);
    @(negedge clk);
    run_i = 1'b1;
    ticks(3);
    check("bp_resume_run", 32'(state_o), 32'd1);
    wait_state("bp_wrap_break", 2'd3, 200);
    check("bp_wrap_pc", 32'(pc_model), 32'd8);
    check("bp_wrap_retired", retired_o, exp_retired);
    check("bp_wrap_drained", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    run_i = 1'b0;
    bp_en_i = 1'b0;
    wait_state("bp_final_halt", 2'd0, 10);

    // Asynchronous reset while an enable is high.
    do_reset();
    push_pcs(0, 2);
    @(negedge clk);
    run_i = 1'b1;
    ticks(6);
    check("rstmid_en_before", 32'(cpu_en_o), 32'd1);
    rst = 1'b1;
    run_i = 1'b0;
    #1;
    check("rstmid_en", 32'(cpu_en_o), 32'd0);
    check("rstmid_state", 32'(state_o), 32'd0);
    check("rstmid_bp_hit", 32'(bp_hit_o), 32'd0);
    check("rstmid_retired", retired_o, 32'd0);
    tick();
    @(negedge clk);
    rst = 1'b0;
    exp_retired = '0;
    ticks(10);
    check("rstmid_stay_halt", 32'(state_o), 32'd0);
    check("rstmid_drained", 32'(exp_q.size()), 32'd0);

    // Step and run together: step first, then RUN; steps in RUN are dropped.
    push_pcs(0, 1);
    @(negedge clk);
    step_i = 1'b1;
    run_i = 1'b1;
    div_sel_i = 2'b11;
    ticks(3);
    check("both_step_first", 32'(state_o), 32'd2);
    tick();
    check("both_step_en", 32'(cpu_en_o), 32'd1);
    tick();
    check("both_then_run", 32'(state_o), 32'd1);
    @(negedge clk);
    step_i = 1'b0;
    ticks(4);
    @(negedge clk);
    step_i = 1'b1;
    ticks(20);
    check("run_step_ignored", 32'(state_o), 32'd1);
    @(negedge clk);
    run_i = 1'b0;
    step_i = 1'b0;
    ticks(10);
    check("run_step_not_queued", 32'(state_o), 32'd0);
    check("both_retired", retired_o, exp_retired);
    check("both_drained", 32'(exp_q.size()), 32'd0);

    // Rate select 01: first enable 2^16 cycles after entering RUN.
    begin
      int n;
      push_pcs(1, 1);
      @(negedge clk);
      div_sel_i = 2'b01;
      run_i = 1'b1;
      wait_state("div01_run", 2'd1, 10);
      n = 0;
      while (cpu_en_o !== 1'b1 && n < 70000) begin
        tick();
        n++;
      end
      check("div01_latency", 32'(n), 32'd65536);
      @(negedge clk);
      run_i = 1'b0;
      wait_state("div01_halt", 2'd0, 10);
      div_sel_i = 2'b00;
    end

    // Retired counter wraps from all-ones.
    @(negedge clk);
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    check("wrap_preload", retired_o, 32'hFFFF_FFFF);
    push_pcs(2, 1);
    @(negedge clk);
    step_i = 1'b1;
    ticks(5);
    check("wrap_retired", retired_o, 32'd0);
    check("wrap_state", 32'(state_o), 32'd0);
    @(negedge clk);
    step_i = 1'b0;
    ticks(4);
    check("final_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
